frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: audio sample width in bits.
REQ-002 Parameter FRAME_LEN, default 4096: samples per emitted frame; power of two.
REQ-003 Parameter HOP, default 2048: new samples between frame starts; power of two, 1 <= HOP <= FRAME_LEN.
REQ-004 clk_in  input  1  single system clock; all logic on its rising edge.
REQ-005 rst_in  input  1  reset, synchronous, active-high.
REQ-006 audio_in  input  DATA_WIDTH  incoming signed audio sample.
REQ-007 audio_in_valid  input  1  audio_in is valid this cycle; at most one sample per cycle.
REQ-008 out_sample  output  DATA_WIDTH  frame sample to the window stage.
REQ-009 out_valid  output  1  out_sample is valid this cycle.
REQ-010 out_first  output  1  high with out_valid on sample 0 of a frame.
REQ-011 out_last  output  1  high with out_valid on sample FRAME_LEN-1 of a frame.
REQ-012 overrun  output  1  sticky flag: a frame trigger was lost.

Function
REQ-013 Storage: circular buffer of FRAME_LEN entries; write pointer wr_ptr increments modulo FRAME_LEN on every audio_in_valid, with no backpressure.
REQ-014 FSM states FILL, WAIT, EMIT; reset enters FILL.
REQ-015 FILL: count writes; after the FRAME_LENth write, go to EMIT the next cycle.
REQ-016 WAIT: hop counter counts writes; on the HOPth write, go to EMIT and clear the hop counter.
REQ-017 EMIT entry: rd_ptr is latched to wr_ptr after including any same-cycle write, so it points at the oldest sample; the frame is the newest FRAME_LEN samples, oldest first.
REQ-018 EMIT: issue one read per cycle for FRAME_LEN consecutive cycles, with rd_ptr incrementing modulo FRAME_LEN.
REQ-019 After the last read: go to EMIT if pending is set (clear pending), else go to WAIT.
REQ-020 The hop counter keeps counting writes during EMIT.
REQ-021 If the hop count reaches HOP during EMIT, set pending.
REQ-022 If the hop count reaches HOP during EMIT while pending is already set, set overrun; the trigger is discarded.
REQ-023 Read latency is 2 cycles (registered RAM output); out_valid, out_first and out_last are delay-matched to the data.
REQ-024 out_valid is high for exactly FRAME_LEN consecutive cycles per frame; out_first and out_last each pulse once per frame.
REQ-025 Write/read collision: a write can never reach an unread address, because reads advance every cycle and writes at most every cycle. A same-address same-cycle access returns the old (read-first) data.
REQ-026 Pointer and counter widths: $clog2(FRAME_LEN) bits, wrapping naturally; the hop counter is $clog2(HOP)+1 bits.
REQ-027 out_sample is passed through unmodified; no arithmetic is applied.

Reset
REQ-028 Reset clears wr_ptr, rd_ptr, all counters and pending; the state returns to FILL.
REQ-029 Reset drives out_sample=0, out_valid=0, out_first=0, out_last=0, overrun=0 from the next cycle.
REQ-030 Reset mid-EMIT aborts the frame: no further out_valid, and the in-flight pipeline stages are cleared.
REQ-031 After reset, buffer contents are don't-care; a full FILL is required before the next frame.

Structure
REQ-032 A shared package audio_frame_pkg holds the FSM state enum typedef (FILL/WAIT/EMIT) and the default FRAME_LEN/HOP constants.
REQ-033 One sub-module: a simple dual-port one-clock BRAM, xilinx_simple_dual_port_1_clock_ram, with RAM_WIDTH=DATA_WIDTH, RAM_DEPTH=FRAME_LEN, HIGH_PERFORMANCE.
REQ-034 All other logic (FSM, counters, valid pipeline) is in frame_sequencer.

Verification
REQ-035 FRAME_LEN=8, HOP=4; write samples 1..8, one every 3 cycles -> one frame 1,2,...,8. out_first on 1, out_last on 8, contiguous valid, first output 2 cycles after EMIT entry.
REQ-036 Continue from REQ-035 with samples 9..12 -> second frame 5..12, then 9..16 after 13..16; no overrun.
REQ-037 Samples every cycle (FRAME_LEN=8, HOP=4) -> back-to-back frames via pending, with out_valid continuous across the frame boundary; overrun stays 0.
REQ-038 HOP=1, FRAME_LEN=8, samples every cycle -> a second trigger during EMIT with pending set makes overrun=1 and keeps it stuck until reset.
REQ-039 Assert rst_in on the 4th valid output of a frame -> out_valid=0 from the next cycle. The next frame appears only after 8 fresh writes and contains only post-reset samples.
REQ-040 Write 0x80 and 0x7F at the wrap boundary (wr_ptr 7->0) -> frame order is preserved and signed extremes are passed through bit-exact.

Source files
------------

// File: rtl/audio_frame_pkg.sv
// Shared definitions for the audio framing path: the frame sequencer FSM
// states and the default frame geometry (frame length and hop).
package audio_frame_pkg;

    // Frame sequencer control states
    typedef enum logic [1:0] {
        FILL = 2'd0,  // priming the buffer after reset
        WAIT = 2'd1,  // idle, counting writes towards the next hop
        EMIT = 2'd2   // streaming one frame out, one sample per cycle
    } seq_state_t;

    localparam int DEFAULT_FRAME_LEN = 4096;
    localparam int DEFAULT_HOP       = 2048;

endpackage

// File: rtl/xilinx_simple_dual_port_1_clock_ram.sv
// Simple dual-port block RAM, single clock. Port A writes, port B reads.
// The read is read-first: a same-address same-cycle write returns the old
// word. With HIGH_PERFORMANCE an output register adds a second cycle of
// latency; rstb clears that register and regceb qualifies its update.
module xilinx_simple_dual_port_1_clock_ram #(
    parameter int    RAM_WIDTH       = 8,
    parameter int    RAM_DEPTH       = 4096,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         enb,
    input  logic                         rstb,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] mem_r [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_r;

    // Write port: store the incoming word when enabled
    always_ff @(posedge clka) begin
        if (wea) begin
            mem_r[addra] <= dina;
        end
    end

    // Read port: first pipeline stage, old contents on address collision
    always_ff @(posedge clka) begin
        if (enb) begin
            ram_data_r <= mem_r[addrb];
        end
    end

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
        assign doutb = ram_data_r;
    end else begin : g_out_reg
        logic [RAM_WIDTH-1:0] doutb_r;

        // Output register: cleared by rstb, loaded only when regceb qualifies it
        always_ff @(posedge clka) begin
            if (rstb) begin
                doutb_r <= {RAM_WIDTH{1'b0}};
            end else if (regceb) begin
                doutb_r <= ram_data_r;
            end
        end

        assign doutb = doutb_r;
    end

endmodule

// File: rtl/frame_sequencer.sv
// Overlapping frame sequencer. Incoming samples are written into a circular
// buffer of FRAME_LEN entries. Once the buffer has been primed, a frame of the
// newest FRAME_LEN samples (oldest first) is streamed out every HOP writes.
// A hop trigger that arrives while a frame is still streaming is held as
// pending; a second one while pending is already held is dropped and flagged
// on the sticky overrun output.
module frame_sequencer
    import audio_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = DEFAULT_FRAME_LEN,
    parameter int HOP        = DEFAULT_HOP
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] audio_in,
    input  logic                  audio_in_valid,
    output logic [DATA_WIDTH-1:0] out_sample,
    output logic                  out_valid,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  overrun
);

    localparam int PTR_W = $clog2(FRAME_LEN);
    localparam int HOP_W = $clog2(HOP) + 1;

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [HOP_W-1:0] HOP_LAST = HOP_W'(HOP - 1);
    localparam logic [HOP_W-1:0] HOP_ZERO = {HOP_W{1'b0}};
    localparam logic [HOP_W-1:0] HOP_ONE  = HOP_W'(1);

    seq_state_t       state_r, state_s;
    logic [PTR_W-1:0] wr_ptr_r, wr_ptr_next_s;
    logic [PTR_W-1:0] rd_ptr_r, rd_ptr_s;
    logic [PTR_W-1:0] fill_cnt_r, fill_cnt_s;
    logic [PTR_W-1:0] rd_cnt_r, rd_cnt_s;
    logic [HOP_W-1:0] hop_cnt_r, hop_cnt_s;
    logic             pending_r, pending_s;
    logic             overrun_r, overrun_s;

    logic             wr_en_s;
    logic             hop_hit_s;
    logic             rd_en_s, rd_first_s, rd_last_s;

    logic             rd_v1_r, rd_first1_r, rd_last1_r;
    logic             out_valid_r, out_first_r, out_last_r;

    // Writes are never back-pressured; reset suppresses the one in its cycle
    assign wr_en_s       = audio_in_valid & ~rst_in;
    // Write pointer as seen after this cycle's write, used when latching rd_ptr
    assign wr_ptr_next_s = audio_in_valid ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    // This cycle's write completes a hop
    assign hop_hit_s     = audio_in_valid & (hop_cnt_r == HOP_LAST);

    // Next-state, pointer and counter logic for the sequencer FSM
    always_comb begin
        state_s    = state_r;
        rd_ptr_s   = rd_ptr_r;
        fill_cnt_s = fill_cnt_r;
        rd_cnt_s   = rd_cnt_r;
        hop_cnt_s  = hop_cnt_r;
        pending_s  = pending_r;
        overrun_s  = overrun_r;
        rd_en_s    = 1'b0;
        rd_first_s = 1'b0;
        rd_last_s  = 1'b0;

        case (state_r)
            FILL: begin
                hop_cnt_s = HOP_ZERO;
                if (audio_in_valid) begin
                    fill_cnt_s = fill_cnt_r + PTR_ONE;
                    if (fill_cnt_r == LAST_IDX) begin
                        state_s  = EMIT;
                        rd_ptr_s = wr_ptr_next_s;
                        rd_cnt_s = PTR_ZERO;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    fill_cnt_s = fill_cnt_r;
                end
            end

            WAIT: begin
                if (hop_hit_s) begin
                    hop_cnt_s = HOP_ZERO;
                    state_s   = EMIT;
                    rd_ptr_s  = wr_ptr_next_s;
                    rd_cnt_s  = PTR_ZERO;
                end else if (audio_in_valid) begin
                    hop_cnt_s = hop_cnt_r + HOP_ONE;
                end else begin
                    hop_cnt_s = hop_cnt_r;
                end
            end

            EMIT: begin
                rd_en_s    = 1'b1;
                rd_first_s = (rd_cnt_r == PTR_ZERO);
                rd_last_s  = (rd_cnt_r == LAST_IDX);
                rd_ptr_s   = rd_ptr_r + PTR_ONE;
                rd_cnt_s   = rd_cnt_r + PTR_ONE;

                // Hop counting carries on while the frame streams out
                if (hop_hit_s) begin
                    hop_cnt_s = HOP_ZERO;
                end else if (audio_in_valid) begin
                    hop_cnt_s = hop_cnt_r + HOP_ONE;
                end else begin
                    hop_cnt_s = hop_cnt_r;
                end

                if (rd_cnt_r == LAST_IDX) begin
                    // Frame done. A held trigger or one landing right now
                    // starts the next frame back-to-back. If both exist, the
                    // held one is served and the new one becomes pending.
                    if (pending_r || hop_hit_s) begin
                        state_s  = EMIT;
                        rd_ptr_s = wr_ptr_next_s;
                        rd_cnt_s = PTR_ZERO;
                    end else begin
                        state_s = WAIT;
                    end
                    pending_s = pending_r & hop_hit_s;
                end else begin
                    if (hop_hit_s && pending_r) begin
                        overrun_s = 1'b1;
                    end else if (hop_hit_s) begin
                        pending_s = 1'b1;
                    end else begin
                        pending_s = pending_r;
                    end
                end
            end

            default: begin
                state_s = FILL;
            end
        endcase
    end

    // Sequencer state, pointers, counters and flags
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r    <= FILL;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            fill_cnt_r <= PTR_ZERO;
            rd_cnt_r   <= PTR_ZERO;
            hop_cnt_r  <= HOP_ZERO;
            pending_r  <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            wr_ptr_r   <= wr_ptr_next_s;
            rd_ptr_r   <= rd_ptr_s;
            fill_cnt_r <= fill_cnt_s;
            rd_cnt_r   <= rd_cnt_s;
            hop_cnt_r  <= hop_cnt_s;
            pending_r  <= pending_s;
            overrun_r  <= overrun_s;
        end
    end

    // Delay the read strobes by two cycles to line up with the RAM data
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_v1_r     <= 1'b0;
            rd_first1_r <= 1'b0;
            rd_last1_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_first_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            rd_v1_r     <= rd_en_s;
            rd_first1_r <= rd_first_s;
            rd_last1_r  <= rd_last_s;
            out_valid_r <= rd_v1_r;
            out_first_r <= rd_first1_r;
            out_last_r  <= rd_last1_r;
        end
    end

    // Sample store; the output register only loads for valid reads, so the
    // sample path is a pure pass-through of the stored bits
    xilinx_simple_dual_port_1_clock_ram #(
        .RAM_WIDTH       (DATA_WIDTH),
        .RAM_DEPTH       (FRAME_LEN),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
    ) u_frame_ram (
        .addra  (wr_ptr_r),
        .addrb  (rd_ptr_r),
        .dina   (audio_in),
        .clka   (clk_in),
        .wea    (wr_en_s),
        .enb    (rd_en_s),
        .rstb   (rst_in),
        .regceb (rd_v1_r),
        .doutb  (out_sample)
    );

    assign out_valid = out_valid_r;
    assign out_first = out_first_r;
    assign out_last  = out_last_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer. The main instance (FRAME_LEN=8,
// HOP=4) is compared every cycle against a reference model that keeps the
// full write history and builds each frame from it; a second instance with
// HOP=1 shares the stimulus and is checked for overrun behaviour.
module tb_frame_sequencer;

    localparam int FL    = 8;
    localparam int HOP_M = 4;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [7:0] audio_in = 8'h00;
    logic       audio_in_valid = 1'b0;

    logic [7:0] out_sample;
    logic       out_valid, out_first, out_last, overrun;
    logic [7:0] h1_sample;
    logic       h1_valid, h1_first, h1_last, h1_overrun;

    always #5 clk_in = ~clk_in;

    frame_sequencer #(.DATA_WIDTH(8), .FRAME_LEN(FL), .HOP(HOP_M)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .audio_in(audio_in),
        .audio_in_valid(audio_in_valid), .out_sample(out_sample),
        .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
        .overrun(overrun)
    );

    frame_sequencer #(.DATA_WIDTH(8), .FRAME_LEN(FL), .HOP(1)) dut_h1 (
        .clk_in(clk_in), .rst_in(rst_in), .audio_in(audio_in),
        .audio_in_valid(audio_in_valid), .out_sample(h1_sample),
        .out_valid(h1_valid), .out_first(h1_first), .out_last(h1_last),
        .overrun(h1_overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] hist[$];
    logic [7:0] snap[FL];
    int  fill_cnt, since, idx;
    bit  filled, emitting, pending, m_overrun;
    bit  p_v, p_f, p_l, e_v, e_f, e_l, e_rst;
    logic [7:0] p_d, e_d;

    // Observation
    logic [7:0] got_q[$];
    logic [7:0] h1_q[$];
    logic [7:0] exp_q[$];
    int run_len, max_run, vcnt, h1_nfirst, h1_nlast;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s @%0t: observed 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // One cycle of the reference: frames are snapshots of the newest FL writes
    task automatic model_cycle(input bit v, input logic [7:0] d, input bit rst);
        bit c_v, c_f, c_l, trig, start;
        logic [7:0] c_d;
        if (rst) begin
            hist.delete();
            fill_cnt = 0; since = 0; idx = 0;
            filled = 0; emitting = 0; pending = 0; m_overrun = 0;
            p_v = 0; p_f = 0; p_l = 0; p_d = 8'h00;
            e_v = 0; e_f = 0; e_l = 0; e_d = 8'h00; e_rst = 1;
        end else begin
            e_rst = 0;
            c_v = emitting;
            c_d = emitting ? snap[idx] : 8'h00;
            c_f = emitting && (idx == 0);
            c_l = emitting && (idx == FL - 1);
            if (v) hist.push_back(d);
            trig = 0;
            start = 0;
            if (!filled) begin
                if (v) begin
                    fill_cnt++;
                    if (fill_cnt == FL) begin filled = 1; trig = 1; end
                end
            end else if (v) begin
                since++;
                if (since == HOP_M) begin since = 0; trig = 1; end
            end
            if (emitting && !c_l) begin
                if (trig) begin
                    if (pending) m_overrun = 1; else pending = 1;
                end
                idx++;
            end else if (emitting) begin
                start = pending || trig;
                pending = pending && trig;
                emitting = 0;
            end else begin
                start = trig;
            end
            if (start) begin
                for (int i = 0; i < FL; i++) snap[i] = hist[hist.size() - FL + i];
                emitting = 1;
                idx = 0;
            end
            e_v = p_v; e_f = p_f; e_l = p_l; e_d = p_d;
            p_v = c_v; p_f = c_f; p_l = c_l; p_d = c_d;
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit rst);
        audio_in = d;
        audio_in_valid = v;
        rst_in = rst;
        model_cycle(v, d, rst);
        @(posedge clk_in);
        #1;
        check("out_valid", 32'(out_valid), 32'(e_v));
        check("out_first", 32'(out_first), 32'(e_f));
        check("out_last", 32'(out_last), 32'(e_l));
        if (e_v || e_rst) check("out_sample", 32'(out_sample), 32'(e_d));
        check("overrun", 32'(overrun), 32'(m_overrun));
        if (out_valid) begin
            got_q.push_back(out_sample);
            vcnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (h1_valid) h1_q.push_back(h1_sample);
        if (h1_first) h1_nfirst++;
        if (h1_last) h1_nlast++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic write_spaced(input logic [7:0] d, input int gap);
        step(1'b1, d, 1'b0);
        idle(gap - 1);
    endtask

    task automatic clear_obs();
        got_q.delete(); h1_q.delete();
        run_len = 0; max_run = 0; vcnt = 0; h1_nfirst = 0; h1_nlast = 0;
    endtask

    task automatic check_stream(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check(tag, 32'(got[i]), 32'(exp[i]));
    endtask

    initial begin
        bit found;
        int rate;
        int rates[4] = '{30, 60, 90, 100};

        // Reset state
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_sample", 32'(out_sample), 32'(0));
        check("rst_overrun", 32'(overrun), 32'(0));
        check("rst_h1_overrun", 32'(h1_overrun), 32'(0));

        // One write every three cycles: frames 1..8, 5..12, 9..16
        clear_obs();
        for (int k = 1; k <= 16; k++) write_spaced(8'(k), 3);
        idle(20);
        exp_q.delete();
        for (int k = 1; k <= 8; k++) exp_q.push_back(8'(k));
        for (int k = 5; k <= 12; k++) exp_q.push_back(8'(k));
        for (int k = 9; k <= 16; k++) exp_q.push_back(8'(k));
        check_stream("spaced_frames", got_q, exp_q);
        check("spaced_overrun", 32'(overrun), 32'(0));

        // Every-cycle writes: back-to-back frames with continuous valid
        step(1'b0, 8'h00, 1'b1);
        check("h1_overrun_cleared", 32'(h1_overrun), 32'(0));
        clear_obs();
        for (int k = 1; k <= 12; k++) step(1'b1, 8'(k), 1'b0);
        idle(30);
        exp_q.delete();
        for (int k = 1; k <= 8; k++) exp_q.push_back(8'(k));
        for (int k = 5; k <= 12; k++) exp_q.push_back(8'(k));
        check_stream("b2b_frames", got_q, exp_q);
        check("b2b_contiguous", 32'(max_run), 32'(2 * FL));
        check("b2b_overrun", 32'(overrun), 32'(0));
        check("h1_overrun_set", 32'(h1_overrun), 32'(1));
        check_stream("h1_frames", h1_q, exp_q);
        check("h1_first_cnt", 32'(h1_nfirst), 32'(2));
        check("h1_last_cnt", 32'(h1_nlast), 32'(2));
        idle(10);
        check("h1_overrun_sticky", 32'(h1_overrun), 32'(1));

        // Reset on the 4th valid output of a frame
        step(1'b0, 8'h00, 1'b1);
        clear_obs();
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            step(1'b1, 8'(8'h40 + c), 1'b0);
            if (vcnt == 4) found = 1;
        end
        check("mid_frame_reached", 32'(found), 32'(1));
        step(1'b0, 8'h00, 1'b1);
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        clear_obs();
        for (int k = 0; k < 8; k++) write_spaced(8'(8'h60 + k), 2);
        idle(15);
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(8'(8'h60 + k));
        check_stream("post_rst_frame", got_q, exp_q);

        // Signed extremes across the wr_ptr 7->0 wrap
        step(1'b0, 8'h00, 1'b1);
        clear_obs();
        for (int k = 1; k <= 7; k++) write_spaced(8'(k), 3);
        write_spaced(8'h80, 3);
        write_spaced(8'h7F, 3);
        for (int k = 10; k <= 12; k++) write_spaced(8'(k), 3);
        idle(20);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h80,
                  8'h05, 8'h06, 8'h07, 8'h80, 8'h7F, 8'h0A, 8'h0B, 8'h0C};
        check_stream("wrap_extremes", got_q, exp_q);

        // Randomized traffic against the reference model
        step(1'b0, 8'h00, 1'b1);
        for (int c = 0; c < 800; c++) begin
            rate = rates[c / 200];
            if ($urandom_range(399, 0) == 0) begin
                step(1'b0, 8'h00, 1'b1);
            end else begin
                step(($urandom_range(99, 0) < 32'(rate)), 8'($urandom), 1'b0);
            end
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
